// File: rtl/div_pkg.sv
//------------------------------------------------------------------------------
// div_pkg : shared types and constants for the sequential integer divider
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Encoding matches funct3[1:0] of the RV32M divide instructions
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DIVIDE = 2'b01,
    S_FIXUP  = 2'b10,
    S_DONE   = 2'b11
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/divider_step.sv
//------------------------------------------------------------------------------
// divider_step : one combinational restoring-division iteration
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  assign w_shift = {i_rem, i_quot[WIDTH-1]};

  // The WIDTH+1-bit trial subtract is non-negative exactly when shift >= divisor;
  // the surviving remainder is always below the divisor, so WIDTH bits hold it.
  assign w_ge   = (w_shift >= {1'b0, i_divisor});
  assign o_rem  = w_ge ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
  assign o_quot = {i_quot[WIDTH-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/divider_seq.sv
//------------------------------------------------------------------------------
// divider_seq : sequential radix-2 restoring divider for DIV/DIVU/REM/REMU
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module divider_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_kill,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_div;
  logic             r_sel_rem;
  logic             r_neg;
  logic [WIDTH-1:0] r_result;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_accept;
  logic [WIDTH-1:0] w_special;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quot;
  logic [WIDTH-1:0] w_fix_val;
  logic [WIDTH-1:0] w_fix_res;

  assign w_signed   = ~i_op[0];
  assign w_a_neg    = w_signed & i_dividend[WIDTH-1];
  assign w_b_neg    = w_signed & i_divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag    = w_b_neg ? -i_divisor : i_divisor;
  assign w_div_zero = (i_divisor == '0);
  assign w_ovf      = w_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (i_divisor == '1);
  assign w_accept   = (r_state == S_IDLE) && i_start && !i_kill;

  // Division by zero and the signed-overflow case bypass the iteration
  assign w_special  = w_div_zero ? (i_op[1] ? i_dividend : '1)
                                 : (i_op[1] ? '0 : i_dividend);

  assign w_fix_val  = r_sel_rem ? r_rem : r_quot;
  assign w_fix_res  = r_neg ? -w_fix_val : w_fix_val;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_div),
    .o_rem     (w_step_rem),
    .o_quot    (w_step_quot)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_div     <= '0;
      r_sel_rem <= 1'b0;
      r_neg     <= 1'b0;
      r_result  <= '0;
    end else if (i_kill && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sel_rem <= i_op[1];
            r_neg     <= i_op[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
            if (w_div_zero || w_ovf) begin
              r_result <= w_special;
              r_state  <= S_DONE;
            end else begin
              r_rem   <= '0;
              r_quot  <= w_a_mag;
              r_div   <= w_b_mag;
              r_cnt   <= CNT_W'(WIDTH);
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_rem  <= w_step_rem;
          r_quot <= w_step_quot;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE);
  assign o_busy   = (r_state == S_DIVIDE) || (r_state == S_FIXUP);
  assign o_valid  = (r_state == S_DONE) && !i_kill;
  assign o_result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_divider_seq.sv
//------------------------------------------------------------------------------
// tb_divider_seq : scoreboard bench for divider_seq against an arithmetic model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_divider_seq;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  cyc;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         kill = 1'b0;
  logic         ready;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;

  int unsigned  cyc = 0;
  int           errors = 0;
  int           checks = 0;
  bit           done = 1'b0;
  exp_t         q[$];

  divider_seq dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_dividend (dividend),
    .i_divisor  (divisor),
    .i_kill     (kill),
    .o_ready    (ready),
    .o_busy     (busy),
    .o_valid    (valid),
    .o_result   (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RISC-V semantics expressed directly with language-level division
  function automatic logic [W-1:0] ref_div(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sr;
    bit ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      2'b00: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        sr = sa / sb;
        return sr;
      end
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        sr = sa % sb;
        return sr;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    exp_t e;
    int   n;
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", {31'b0, ready}, 32'h1);
    end
    start    = 1'b1;
    op       = f;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.res = ref_div(f, a, b);
      e.cyc = cyc + (is_special(f, a, b) ? 1 : W + 2);
      e.op  = f;
      e.a   = a;
      e.b   = b;
      q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        chk("ready_in_done", {31'b0, ready}, 32'h0);
        if (q.size() == 0) begin
          chk("unexpected_valid", result, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          if (result !== e.res)
            $display("  op=%0d a=%h b=%h", e.op, e.a, e.b);
          chk("result", result, e.res);
          chk("latency", cyc, e.cyc);
        end
      end
    end
  endtask

  task automatic stimulus();
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic unsigned with busy-length check
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    n = 0;
    repeat (40) begin
      if (busy) n++;
      tick();
    end
    chk("busy_cycles", n, 32'd33);
    issue(2'b11, 32'd100, 32'd7, 1'b1);
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
    issue(2'b00, 32'd7, 32'hFFFF_FFFE, 1'b1);
    issue(2'b01, 32'd5, 32'd0, 1'b1);
    issue(2'b10, 32'd5, 32'd0, 1'b1);
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // Kill mid-divide, then an immediate new op
    issue(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("ready_after_kill", {31'b0, ready}, 32'h1);
    issue(2'b01, 32'd9, 32'd3, 1'b1);

    // Kill together with start in IDLE must not accept
    while (!ready) tick();
    start = 1'b1;
    kill  = 1'b1;
    op    = 2'b01;
    dividend = 32'd50;
    divisor  = 32'd5;
    tick();
    start = 1'b0;
    kill  = 1'b0;
    chk("kill_start_ready", {31'b0, ready}, 32'h1);
    chk("kill_start_busy", {31'b0, busy}, 32'h0);

    // Start while busy is ignored
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    repeat (3) tick();
    chk("ready_while_busy", {31'b0, ready}, 32'h0);
    start = 1'b1;
    op = 2'b01;
    dividend = 32'd55;
    divisor  = 32'd5;
    tick();
    start = 1'b0;

    // Synchronous reset mid-divide
    issue(2'b01, 32'd123456, 32'd7, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", {31'b0, ready}, 32'h1);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_valid", {31'b0, valid}, 32'h0);
    chk("midrst_result", result, 32'h0);

    // Low pulse between edges is not sampled
    issue(2'b01, 32'd100, 32'd7, 1'b1);
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1);
    end

    n = 0;
    while (q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'h0);
    repeat (40) tick();
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
